// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the IF/ID/EX pipeline.
// A per-register scoreboard holds the instruction in ID until its operands,
// its destination and EX are all free. A taken branch flushes IF/ID for
// FLUSH_CYCLES cycles. A saturating counter records stall cycles.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | normal issue; stalls on hazards; a taken branch flushes once
//   FLUSH | extra post-branch bubbles; issue blocked, branch input ignored
module pipeline_ctrl #(
    parameter int REG_ADDR_W   = 4,
    parameter int NUM_REGS     = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  id_reg_w_en,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_branch_tk,
    input  logic                  ex_busy,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_valid,
    output logic [NUM_REGS-1:0]   busy_regs,
    output logic [15:0]           stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // The branch cycle itself is the first bubble, so the counter only
    // covers the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t              state;
    logic [2:0]          flush_cnt;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                hazard;
    logic                branch_go;

    assign busy_regs = busy;

    // Hazard detection uses only the registered scoreboard; a retiring write
    // is seen one cycle later, which keeps wb_* off every output path.
    always_comb begin
        hazard = id_valid & ((id_rs1_used & busy[id_rs1]) |
                             (id_rs2_used & busy[id_rs2]) |
                             (id_reg_w_en & busy[id_rd])  |
                             ex_busy);
    end

    // Pipeline control outputs from current state and ID-stage inputs.
    always_comb begin
        id_ex_valid = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        branch_go   = 1'b0;
        if (state == FLUSH) begin
            if_id_flush = 1'b1;
        end else begin
            id_ex_valid = id_valid & ~hazard;
            pc_stall    = id_valid & hazard;
            if_id_stall = id_valid & hazard;
            branch_go   = id_valid & ~hazard & id_branch_tk;
            if_id_flush = branch_go;
        end
    end

    // Next scoreboard: clear first so that a same-cycle set of the same index wins.
    always_comb begin
        busy_next = busy;
        if (wb_valid) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (id_ex_valid && id_reg_w_en) begin
            busy_next[id_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // RUN/FLUSH sequencing with the post-branch down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_go && (FLUSH_CYCLES > 1)) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (flush_cnt != 3'd0) begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                    if (flush_cnt <= 3'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state     <= RUN;
                    flush_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter for performance debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (pc_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus random traffic,
// all checked against a cycle-level reference model of the pipeline rules.
module tb_pipeline_ctrl;

    localparam int FC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [3:0]  id_rs1 = '0;
    logic [3:0]  id_rs2 = '0;
    logic        id_rs1_used = 1'b0;
    logic        id_rs2_used = 1'b0;
    logic        id_reg_w_en = 1'b0;
    logic [3:0]  id_rd = '0;
    logic        id_branch_tk = 1'b0;
    logic        ex_busy = 1'b0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_valid;
    logic [15:0] busy_regs;
    logic [15:0] stall_cnt;

    pipeline_ctrl #(.REG_ADDR_W(4), .NUM_REGS(16), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_reg_w_en(id_reg_w_en), .id_rd(id_rd), .id_branch_tk(id_branch_tk),
        .ex_busy(ex_busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_valid(id_ex_valid), .busy_regs(busy_regs), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: set of in-flight destinations, bubbles still owed
    // after the current cycle, and an integer stall total.
    bit  pend[16];
    int  bubbles_left;
    int  stalls;
    bit  exp_issue, exp_stall, exp_flush;
    bit  obs_flush;
    bit  obs_issue;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        bubbles_left = 0;
        stalls = 0;
    endtask

    function automatic logic [15:0] pend_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic compute_exp();
        bit blocked;
        blocked = ex_busy
                  || (id_rs1_used && pend[id_rs1])
                  || (id_rs2_used && pend[id_rs2])
                  || (id_reg_w_en && pend[id_rd]);
        if (bubbles_left > 0) begin
            exp_issue = 1'b0;
            exp_stall = 1'b0;
            exp_flush = 1'b1;
        end else begin
            exp_issue = id_valid && !blocked;
            exp_stall = id_valid && blocked;
            exp_flush = exp_issue && id_branch_tk;
        end
    endtask

    task automatic update_model();
        if (exp_stall && stalls < 65535) stalls++;
        if (bubbles_left > 0) bubbles_left--;
        else if (exp_flush) bubbles_left = FC - 1;
        if (wb_valid) pend[wb_rd] = 1'b0;
        if (exp_issue && id_reg_w_en) pend[id_rd] = 1'b1;
    endtask

    task automatic check_all();
        chk("id_ex_valid", 32'(id_ex_valid), 32'(exp_issue));
        chk("pc_stall", 32'(pc_stall), 32'(exp_stall));
        chk("if_id_stall", 32'(if_id_stall), 32'(exp_stall));
        chk("if_id_flush", 32'(if_id_flush), 32'(exp_flush));
        chk("busy_regs", 32'(busy_regs), 32'(pend_vec()));
        chk("stall_cnt", 32'(stall_cnt), 32'(stalls));
        chk("issue_and_stall", 32'(id_ex_valid & pc_stall), 32'(0));
        chk("stall_and_flush", 32'(if_id_stall & if_id_flush), 32'(0));
    endtask

    // One clock cycle: inputs already driven; check mid-cycle, then advance.
    task automatic cycle(input bit do_chk);
        #3;
        compute_exp();
        if (do_chk) check_all();
        obs_flush = if_id_flush;
        obs_issue = id_ex_valid;
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_reg_w_en = 0; id_rd = 0; id_branch_tk = 0; ex_busy = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input bit we, input int rd, input bit br);
        id_valid = v; id_rs1 = 4'(rs1); id_rs1_used = u1; id_rs2 = 4'(rs2);
        id_rs2_used = u2; id_reg_w_en = we; id_rd = 4'(rd); id_branch_tk = br;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1);
        rst_n = 1'b1;
    endtask

    int flush_seen;

    initial begin
        #2;
        // Reset then idle
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1);
        chk("idle_busy", 32'(busy_regs), 32'h0);

        // RAW stall on r3, released the cycle after wb
        set_id(1, 0, 0, 0, 0, 1, 3, 0);
        cycle(1);
        set_id(1, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1);
        wb_valid = 1; wb_rd = 3;
        cycle(1);
        wb_valid = 0;
        #3;
        chk("raw_issue_after_wb", 32'(id_ex_valid), 32'(1));
        chk("raw_busy3_clear", 32'(busy_regs[3]), 32'(0));
        chk("raw_stall_cnt", 32'(stall_cnt), 32'(4));
        #1 @(posedge clk); update_model(); #1;

        // WAW on r5 and same-cycle set/clear
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 5, 0);
        cycle(1);
        cycle(1);
        cycle(1);
        wb_valid = 1; wb_rd = 5;
        cycle(1);
        cycle(1);
        wb_valid = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1);
        chk("waw_set_wins", 32'(busy_regs[5]), 32'(1));

        // Taken branch, 3 bubbles, repeated branch in FLUSH ignored
        do_reset();
        flush_seen = 0;
        for (int i = 0; i < 5; i++) begin
            set_id(1, 0, 0, 0, 0, 0, 0, (i < 3) ? 1'b1 : 1'b0);
            cycle(1);
            if (obs_flush) flush_seen++;
            if (i == 1 || i == 2) chk("flush_no_issue", 32'(obs_issue), 32'(0));
        end
        chk("flush_count", 32'(flush_seen), 32'(FC));

        // ex_busy for 4 cycles, issue when it drops
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 4, 0);
        ex_busy = 1;
        for (int i = 0; i < 4; i++) cycle(1);
        ex_busy = 0;
        cycle(1);
        chk("exbusy_issue", 32'(obs_issue), 32'(1));
        chk("exbusy_stall_cnt", 32'(stall_cnt), 32'(4));

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 5), $urandom_range(0, 1),
                   $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 5), $urandom_range(0, 9) == 0);
            ex_busy  = ($urandom_range(0, 4) == 0);
            wb_valid = $urandom_range(0, 1);
            wb_rd    = 4'($urandom_range(0, 5));
            cycle(1);
        end

        // Saturation of the stall counter
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 0, 0);
        ex_busy = 1;
        for (int i = 0; i < 70000; i++) cycle(0);
        cycle(1);
        chk("stall_saturated", 32'(stall_cnt), 32'hFFFF);

        // Async reset in the middle of a FLUSH with a pending write
        ex_busy = 0;
        set_id(1, 0, 0, 0, 0, 1, 7, 1);
        cycle(1);
        idle_inputs();
        #3;
        chk("pre_reset_flush", 32'(if_id_flush), 32'(1));
        chk("pre_reset_busy7", 32'(busy_regs[7]), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("async_flush", 32'(if_id_flush), 32'(0));
        chk("async_busy", 32'(busy_regs), 32'h0);
        chk("async_stall_cnt", 32'(stall_cnt), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
